// File: rtl/rob_retire_pkg.sv
// Core-wide declarations shared by rename, the RAT and the reorder buffer retire stage.
// Entry layout and per-entry lifecycle states live here so every stage agrees on them.
package rob_retire_pkg;

  localparam int unsigned ARCH_REG_W = 5;
  localparam int unsigned PREG_W     = 6;
  localparam int unsigned NUM_PREGS  = 64;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ISSUED = 2'd1,
    DONE   = 2'd2
  } rob_state_t;

  typedef struct packed {
    rob_state_t            state;
    logic                  has_rd;
    logic [ARCH_REG_W-1:0] rd;
    logic [PREG_W-1:0]     pd;
    logic [PREG_W-1:0]     old_pd;
  } rob_entry_t;

  // p0 is the hardwired zero register and must never re-enter the free pool.
  function automatic logic frees_preg(rob_entry_t e);
    return e.has_rd && (e.old_pd != '0);
  endfunction

endpackage

// File: rtl/rob_retire_if.sv
// Rename/FU-facing bus of the retire stage: allocate, complete, retire and free-pool return.
interface rob_retire_if
  import rob_retire_pkg::*;
#(
  parameter int unsigned TAG_W = 4
);

  logic                  alloc_valid;
  logic                  alloc_ready;
  logic                  alloc_has_rd;
  logic [ARCH_REG_W-1:0] alloc_rd;
  logic [PREG_W-1:0]     alloc_pd;
  logic [PREG_W-1:0]     alloc_old_pd;
  logic [TAG_W-1:0]      alloc_tag;
  logic                  cmpl_valid;
  logic [TAG_W-1:0]      cmpl_tag;
  logic                  retire_valid;
  logic [ARCH_REG_W-1:0] retire_rd;
  logic [PREG_W-1:0]     retire_pd;
  logic                  free_valid;
  logic [PREG_W-1:0]     free_preg;
  logic [TAG_W:0]        occupancy;
  logic                  cmpl_err;

  modport master (
    output alloc_valid, alloc_has_rd, alloc_rd, alloc_pd, alloc_old_pd, cmpl_valid, cmpl_tag,
    input  alloc_ready, alloc_tag, retire_valid, retire_rd, retire_pd, free_valid, free_preg,
           occupancy, cmpl_err
  );

  modport slave (
    input  alloc_valid, alloc_has_rd, alloc_rd, alloc_pd, alloc_old_pd, cmpl_valid, cmpl_tag,
    output alloc_ready, alloc_tag, retire_valid, retire_rd, retire_pd, free_valid, free_preg,
           occupancy, cmpl_err
  );

endinterface

// File: rtl/rob_retire_entry_array.sv
// Reorder-buffer storage: one allocate write port, one completion state port, and a
// head read port whose entry is cleared when it retires.
module rob_retire_entry_array
  import rob_retire_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_idx,
  input  rob_entry_t       alloc_entry,
  input  logic             cmpl_en,
  input  logic [TAG_W-1:0] cmpl_idx,
  input  logic             retire_en,
  input  logic [TAG_W-1:0] head_idx,
  output rob_entry_t       head_entry,
  output logic             cmpl_hit_free
);

  rob_entry_t entries_q [DEPTH];

  assign head_entry    = entries_q[head_idx];
  assign cmpl_hit_free = cmpl_en && (entries_q[cmpl_idx].state == FREE);

  // The three ports never target the same live entry: retire needs DONE, completion only
  // acts on ISSUED, and allocate only lands on the tail, which is FREE whenever it fires.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!rst_n) begin
        entries_q[i] <= '0;
      end else begin
        if (retire_en && head_idx == TAG_W'(i)) begin
          entries_q[i].state <= FREE;
        end
        if (cmpl_en && cmpl_idx == TAG_W'(i) && entries_q[i].state == ISSUED) begin
          entries_q[i].state <= DONE;
        end
        if (alloc_en && alloc_idx == TAG_W'(i)) begin
          entries_q[i] <= alloc_entry;
        end
      end
    end
  end

endmodule

// File: rtl/rob_retire.sv
// In-order retire stage: allocates ROB entries from rename, retires the oldest completed
// entry each cycle and returns the superseded physical register to the free pool.
module rob_retire
  import rob_retire_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  rob_retire_if.slave rob
);

  localparam logic [TAG_W:0] FullCount = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]      head_q, tail_q;
  logic [TAG_W:0]        occ_q, occ_d;
  logic                  retire_valid_q, free_valid_q, cmpl_err_q;
  logic [ARCH_REG_W-1:0] retire_rd_q;
  logic [PREG_W-1:0]     retire_pd_q, free_preg_q;
  rob_entry_t            head_entry, alloc_entry;
  logic                  alloc_fire, retire_fire, cmpl_hit_free;

  assign rob.alloc_ready  = occ_q < FullCount;
  assign rob.alloc_tag    = tail_q;
  assign rob.retire_valid = retire_valid_q;
  assign rob.retire_rd    = retire_rd_q;
  assign rob.retire_pd    = retire_pd_q;
  assign rob.free_valid   = free_valid_q;
  assign rob.free_preg    = free_preg_q;
  assign rob.occupancy    = occ_q;
  assign rob.cmpl_err     = cmpl_err_q;

  assign alloc_fire  = rob.alloc_valid && rob.alloc_ready;
  assign retire_fire = head_entry.state == DONE;

  always_comb begin
    alloc_entry        = '0;
    alloc_entry.state  = ISSUED;
    alloc_entry.has_rd = rob.alloc_has_rd;
    alloc_entry.rd     = rob.alloc_rd;
    alloc_entry.pd     = rob.alloc_pd;
    alloc_entry.old_pd = rob.alloc_old_pd;
  end

  always_comb begin
    occ_d = occ_q;
    if (alloc_fire && !retire_fire) begin
      occ_d = occ_q + (TAG_W+1)'(1);
    end else if (!alloc_fire && retire_fire) begin
      occ_d = occ_q - (TAG_W+1)'(1);
    end
  end

  rob_retire_entry_array #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_entries (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_en      (alloc_fire),
    .alloc_idx     (tail_q),
    .alloc_entry   (alloc_entry),
    .cmpl_en       (rob.cmpl_valid),
    .cmpl_idx      (rob.cmpl_tag),
    .retire_en     (retire_fire),
    .head_idx      (head_q),
    .head_entry    (head_entry),
    .cmpl_hit_free (cmpl_hit_free)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q         <= '0;
      tail_q         <= '0;
      occ_q          <= '0;
      retire_valid_q <= 1'b0;
      free_valid_q   <= 1'b0;
      cmpl_err_q     <= 1'b0;
      retire_rd_q    <= '0;
      retire_pd_q    <= '0;
      free_preg_q    <= '0;
    end else begin
      occ_q          <= occ_d;
      retire_valid_q <= retire_fire;
      free_valid_q   <= retire_fire && frees_preg(head_entry);
      if (alloc_fire) begin
        tail_q <= tail_q + TAG_W'(1);
      end
      if (retire_fire) begin
        head_q      <= head_q + TAG_W'(1);
        retire_rd_q <= head_entry.rd;
        retire_pd_q <= head_entry.pd;
        free_preg_q <= head_entry.old_pd;
      end
      if (cmpl_hit_free) begin
        cmpl_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Randomised and directed bench for rob_retire: a program-order queue model predicts each
// edge's outputs into a scoreboard that a separate monitor drains after every rising edge.
module tb_rob_retire;
  import rob_retire_pkg::*;

  localparam int DEPTH = 16;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rob_retire_if #(.TAG_W(TAG_W)) bus ();

  rob_retire #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    bit has_rd;
    int rd;
    int pd;
    int old_pd;
  } minst_t;

  typedef struct {
    bit rv;
    int rd;
    int pd;
    bit fv;
    int fp;
    int occ;
    bit err;
  } exp_t;

  // Reference model: instructions in program order plus a per-tag "finished" flag.
  minst_t inflight[$];
  bit     finished[DEPTH];
  int     alloc_count;
  bit     m_err;
  int     last_rd, last_pd, last_fp;
  exp_t   expq[$];

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    inflight.delete();
    foreach (finished[k]) finished[k] = 1'b0;
    alloc_count = 0;
    m_err = 1'b0;
    last_rd = 0;
    last_pd = 0;
    last_fp = 0;
  endfunction

  task automatic step(input bit rst, input bit av, input bit hr, input int rd, input int pd,
                      input int opd, input bit cv, input int ctag);
    exp_t   e;
    minst_t m;
    bit     do_ret, do_alloc, live, mark;
    @(negedge clk);
    rst_n            = !rst;
    bus.alloc_valid  = av;
    bus.alloc_has_rd = hr;
    bus.alloc_rd     = rd[4:0];
    bus.alloc_pd     = pd[5:0];
    bus.alloc_old_pd = opd[5:0];
    bus.cmpl_valid   = cv;
    bus.cmpl_tag     = ctag[3:0];
    #1;
    e = '{default: 0};
    if (rst) begin
      model_reset();
    end else begin
      chk("alloc_ready", int'(bus.alloc_ready), int'(inflight.size() < DEPTH));
      chk("alloc_tag", int'(bus.alloc_tag), alloc_count % DEPTH);
      do_ret   = inflight.size() > 0 && finished[inflight[0].tag];
      do_alloc = av && inflight.size() < DEPTH;
      live = 1'b0;
      mark = 1'b0;
      if (cv) begin
        foreach (inflight[k]) if (inflight[k].tag == ctag) live = 1'b1;
        if (live) mark = 1'b1;
        else m_err = 1'b1;
      end
      if (do_ret) begin
        m = inflight.pop_front();
        last_rd = m.rd;
        last_pd = m.pd;
        last_fp = m.old_pd;
        e.rv = 1'b1;
        e.fv = m.has_rd && m.old_pd != 0;
      end
      if (mark) finished[ctag] = 1'b1;
      if (do_alloc) begin
        m = '{tag: alloc_count % DEPTH, has_rd: hr, rd: rd, pd: pd, old_pd: opd};
        inflight.push_back(m);
        finished[m.tag] = 1'b0;
        alloc_count++;
      end
      e.rd  = last_rd;
      e.pd  = last_pd;
      e.fp  = last_fp;
      e.occ = inflight.size();
      e.err = m_err;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit hr, input int rd, input int pd, input int opd);
    step(0, 1, hr, rd, pd, opd, 0, 0);
  endtask

  task automatic cmpl(input int tag);
    step(0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  // Monitor: compares registered outputs after every edge the driver predicted.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("retire_valid", int'(bus.retire_valid), int'(e.rv));
        chk("free_valid", int'(bus.free_valid), int'(e.fv));
        chk("retire_rd", int'(bus.retire_rd), e.rd);
        chk("retire_pd", int'(bus.retire_pd), e.pd);
        chk("free_preg", int'(bus.free_preg), e.fp);
        chk("occupancy", int'(bus.occupancy), e.occ);
        chk("cmpl_err", int'(bus.cmpl_err), int'(e.err));
      end
    end
  end

  initial begin
    int rd, pd, opd, ctag;
    bit av, cv, hr;
    bus.alloc_valid  = 1'b0;
    bus.alloc_has_rd = 1'b0;
    bus.alloc_rd     = '0;
    bus.alloc_pd     = '0;
    bus.alloc_old_pd = '0;
    bus.cmpl_valid   = 1'b0;
    bus.cmpl_tag     = '0;
    model_reset();

    // Single instruction end to end.
    do_reset();
    do_reset();
    alloc(1, 5, 33, 12);
    cmpl(0);
    idle(3);

    // Out-of-order completion, in-order retire.
    do_reset();
    alloc(1, 1, 40, 20);
    alloc(1, 2, 41, 21);
    alloc(1, 3, 42, 22);
    cmpl(2);
    cmpl(0);
    cmpl(1);
    idle(5);

    // Fill, attempt overflow, drain one, wrap tail.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(1, i + 1, i + 10, i + 30);
    alloc(1, 31, 63, 62);
    cmpl(0);
    idle(2);
    alloc(1, 9, 50, 51);
    idle(1);

    // No free for has_rd=0 or old_pd=p0.
    do_reset();
    alloc(0, 0, 17, 18);
    alloc(1, 4, 19, 0);
    cmpl(0);
    cmpl(1);
    idle(3);

    // Completion to a FREE entry; sticky until reset.
    do_reset();
    cmpl(7);
    idle(3);
    do_reset();
    idle(1);

    // Completion to the tail in its own allocate cycle sees FREE.
    do_reset();
    step(0, 1, 1, 6, 22, 23, 1, 0);
    idle(2);

    // Reset mid-operation with 5 live and 2 DONE.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(1, i + 2, i + 40, i + 50);
    cmpl(1);
    cmpl(2);
    do_reset();
    idle(2);

    // Random traffic with legal completions, occasional mid-run reset.
    for (int i = 0; i < 600; i++) begin
      av  = $urandom_range(0, 3) != 0;
      hr  = $urandom_range(0, 4) != 0;
      rd  = $urandom_range(0, 31);
      pd  = $urandom_range(0, 63);
      opd = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 63);
      cv  = 1'b0;
      ctag = 0;
      if (inflight.size() > 0 && $urandom_range(0, 2) != 0) begin
        cv = 1'b1;
        ctag = inflight[$urandom_range(0, inflight.size() - 1)].tag;
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(0, av, hr, rd, pd, opd, cv, ctag);
    end

    idle(4);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_retire.md
Name: rob_retire

Overview:
- In-order retire stage for the out-of-order core, downstream of rename.
- Rename allocates a reorder-buffer entry for each renamed instruction. That entry carries the new physical destination and the previous mapping of rd.
- Functional units mark entries complete by tag. The block retires the oldest completed entry each cycle and returns the superseded physical register to the free pool. It is the release-side counterpart of rename's allocation.

Parameters:
- DEPTH, 16, number of ROB entries; must be a power of 2 and at least 2.
- TAG_W, 4, tag width; equals log2(DEPTH).
- NUM_PREGS, 64, physical register count; physical register index width is 6.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on rising edge of clk.
- alloc_valid  in  1  rename presents an instruction.
- alloc_ready  out  1  an entry is free; combinational from registered count.
- alloc_has_rd  in  1  instruction writes an architectural register (rd != x0).
- alloc_rd  in  5  architectural destination.
- alloc_pd  in  6  newly mapped physical destination.
- alloc_old_pd  in  6  physical register previously mapped to rd.
- alloc_tag  out  TAG_W  tag the entry will receive; equals the tail index; combinational.
- cmpl_valid  in  1  functional-unit completion.
- cmpl_tag  in  TAG_W  tag of the completing entry.
- retire_valid  out  1  registered; one instruction retired this cycle.
- retire_rd  out  5  registered; architectural rd of the retired entry, for the retirement RAT.
- retire_pd  out  6  registered; physical destination of the retired entry.
- free_valid  out  1  registered; free_preg is being returned to the free pool.
- free_preg  out  6  registered; the physical register being freed.
- occupancy  out  TAG_W+1  registered count of live entries.
- cmpl_err  out  1  sticky; set when a completion hits a FREE entry.

Behaviour:
- Per-entry state:
  - FREE -> ISSUED on allocate.
  - ISSUED -> DONE on a matching completion.
  - DONE -> FREE on retire.
  - No other transitions.
- Pointers: head and tail are TAG_W bits and wrap modulo DEPTH. Full and empty are derived from occupancy, never from pointer compare.
- Allocate:
  - Occurs on a rising edge when alloc_valid && alloc_ready.
  - Writes entry[tail] = {ISSUED, has_rd, rd, pd, old_pd}, then increments tail.
  - alloc_ready = (occupancy < DEPTH). A retire in the same cycle does not raise alloc_ready while full.
- Complete:
  - When cmpl_valid and entry[cmpl_tag] is ISSUED, the entry becomes DONE at the edge.
  - A completion to a DONE entry is ignored, with no error.
  - A completion to a FREE entry is ignored and sets cmpl_err, which stays set until reset.
- Retire:
  - At each edge, if entry[head] is DONE (its registered state): entry becomes FREE, head increments.
  - Retire outputs are registered: retire_valid=1, retire_rd, retire_pd.
  - free_valid = has_rd && (old_pd != 0). Physical register p0 is hardwired zero and is never freed. free_preg = old_pd.
  - Otherwise retire_valid and free_valid are 0. Data outputs hold their previous values.
  - At most 1 retire per cycle.
- Latency:
  - A completion sampled at edge E makes the entry DONE after E.
  - The earliest retire is at edge E+1, so retire_valid is high in the cycle after E+1.
  - An instruction allocated and completed in consecutive cycles therefore retires no earlier than 2 edges after its allocate.
- Simultaneous events:
  - Allocate, complete and retire may all occur in the same cycle.
  - occupancy_next = occupancy + alloc_fire - retire_fire.
  - A completion and a retire targeting the same entry cannot coincide, because retire requires DONE already.
  - A completion to the tail index in the same cycle as its allocate sees FREE and sets cmpl_err.
- Wrap-around: the tag after DEPTH-1 is 0. Entry reuse after retire is legal in the next cycle.
- Reset, including mid-operation:
  - All entries become FREE; head = tail = 0; occupancy = 0.
  - retire_valid = free_valid = cmpl_err = 0; retire_rd = retire_pd = free_preg = 0.
  - In-flight entries are dropped and no frees are emitted. Rename is reset in the same cycle.

Decomposition:
- Shared package (core-wide, alongside the existing RAT and physical-register declarations) holds:
  - ARCH_REG_W=5, PREG_W=6, NUM_PREGS=64.
  - rob_state_t enum {FREE, ISSUED, DONE}.
  - rob_entry_t struct {state, has_rd, rd, pd, old_pd}.
- One sub-module is natural: rob_entry_array, a DEPTH-deep register array with one write port (allocate), one state-update port (complete), one read/clear port (retire at head).
- Pointer, occupancy and retire-output logic stay in the top.

Test Plan:
- Reset, then allocate {rd=5, pd=33, old_pd=12}, complete tag 0 -> retire_valid, retire_rd=5, retire_pd=33, free_valid, free_preg=12 in the cycle after the second edge following completion.
- Allocate tags 0, 1, 2; complete in order 2, 0, 1 -> exactly three retires, in tag order 0, 1, 2, one per cycle, beginning after tag 1's completion.
- Allocate 16 entries without completing -> alloc_ready=0, occupancy=16. Complete tag 0 -> after the retire, alloc_ready=1, and the next allocate receives alloc_tag=0 (wrap).
- Allocate with has_rd=0, and a second entry with old_pd=0; complete both -> retire_valid=1 for both, free_valid=0 for both.
- Complete tag 7 while the ROB is empty -> cmpl_err=1 and stays set, no retire. Reset -> cmpl_err=0.
- Apply reset while 5 entries are live and 2 are DONE -> the next cycle shows occupancy=0, no retire_valid or free_valid, and alloc_tag=0.
